// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle for the 1-to-2 stream demux: one producer-facing input stream
// and two consumer-facing output lanes.
interface stream_demux_1x2_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_valid;
    logic              out1_ready;

    // The demux itself: consumes the input stream, produces both lanes.
    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid
    );

    // The surrounding producer/consumers.
    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid
    );
endinterface

// File: rtl/stream_demux_1x2.sv
// Routes one valid/ready stream to one of two lanes chosen per beat by in_sel.
// Each lane has a one-entry output register and a wrapping delivered-beat counter.
module stream_demux_1x2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    stream_demux_1x2_if.slave   bus,
    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } laneState_e;

    laneState_e        state_q [2];
    laneState_e        state_d [2];
    logic [DATA_W-1:0] data_q  [2];
    logic [DATA_W-1:0] data_d  [2];
    logic [CNT_W-1:0]  cnt_q   [2];
    logic [CNT_W-1:0]  cnt_d   [2];

    logic [1:0] outReady;
    logic [1:0] drain;
    logic [1:0] load;
    logic       inReady;

    assign outReady = {bus.out1_ready, bus.out0_ready};

    // Only the addressed lane gates in_ready, so a stalled lane never blocks the other.
    always_comb begin
        drain   = '0;
        load    = '0;
        inReady = !rst && ((state_q[bus.in_sel] == EMPTY) || outReady[bus.in_sel]);
        for (int n = 0; n < 2; n++) begin
            drain[n] = (state_q[n] == FULL) && outReady[n];
            load[n]  = bus.in_valid && inReady && (bus.in_sel == 1'(n));
        end
    end

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            data_d[n]  = data_q[n];
            cnt_d[n]   = cnt_q[n] + CNT_W'(drain[n]);
            if (load[n]) begin
                data_d[n] = bus.in_data;
            end
            case (state_q[n])
                EMPTY: begin
                    if (load[n]) begin
                        state_d[n] = FULL;
                    end
                end
                FULL: begin
                    if (drain[n] && !load[n]) begin
                        state_d[n] = EMPTY;
                    end
                end
                default: state_d[n] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= EMPTY;
                data_q[n]  <= '0;
                cnt_q[n]   <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                data_q[n]  <= data_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out0_valid = (state_q[0] == FULL);
    assign bus.out0_data  = data_q[0];
    assign bus.out1_valid = (state_q[1] == FULL);
    assign bus.out1_data  = data_q[1];
    assign cnt0           = cnt_q[0];
    assign cnt1           = cnt_q[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Self-checking bench for stream_demux_1x2: directed scenarios plus a random phase,
// all compared against per-lane queues and delivered-beat tallies.
module tb_stream_demux_1x2;

    logic clk;
    logic rst;

    int checks;
    int failures;

    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [3:0]  wcnt0;
    logic [3:0]  wcnt1;

    stream_demux_1x2_if #(.DATA_W(8)) bus ();
    stream_demux_1x2_if #(.DATA_W(8)) wbus ();

    stream_demux_1x2 #(.DATA_W(8), .CNT_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    // Second instance with a narrow counter so the wrap can be reached quickly.
    stream_demux_1x2 #(.DATA_W(8), .CNT_W(4)) dutWrap (
        .clk  (clk),
        .rst  (rst),
        .bus  (wbus),
        .cnt0 (wcnt0),
        .cnt1 (wcnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         mc0;
    int         mc1;
    logic       lastStall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expReady();
        if (rst) return 1'b0;
        if (bus.in_sel) return (q1.size() == 0) || bus.out1_ready;
        return (q0.size() == 0) || bus.out0_ready;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [7:0] d,
                         input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic tick(input string tag);
        logic rdy;
        logic acc;
        #1;
        rdy = expReady();
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, ".out0_valid"}, 32'(bus.out0_valid), 32'(q0.size() > 0));
        chk({tag, ".out1_valid"}, 32'(bus.out1_valid), 32'(q1.size() > 0));
        if (q0.size() > 0) chk({tag, ".out0_data"}, 32'(bus.out0_data), 32'(q0[0]));
        if (q1.size() > 0) chk({tag, ".out1_data"}, 32'(bus.out1_data), 32'(q1[0]));
        chk({tag, ".cnt0"}, 32'(cnt0), 32'(mc0 % 65536));
        chk({tag, ".cnt1"}, 32'(cnt1), 32'(mc1 % 65536));
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            mc0 = 0;
            mc1 = 0;
            lastStall = 1'b0;
        end else begin
            acc       = bus.in_valid && rdy;
            lastStall = bus.in_valid && !rdy;
            if (q0.size() > 0 && bus.out0_ready) begin
                void'(q0.pop_front());
                mc0++;
            end
            if (q1.size() > 0 && bus.out1_ready) begin
                void'(q1.pop_front());
                mc1++;
            end
            if (acc) begin
                if (bus.in_sel) q1.push_back(bus.in_data);
                else            q0.push_back(bus.in_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic doReset(input int cycles, input logic r0, input logic r1);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, r0, r1);
        for (int i = 0; i < cycles; i++) tick("reset");
        #1;
        chk("reset.out0_data", 32'(bus.out0_data), 32'h0);
        chk("reset.out1_data", 32'(bus.out1_data), 32'h0);
        chk("reset.in_ready_low", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mc0       = 0;
        mc1       = 0;
        lastStall = 1'b0;
        rst       = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        wbus.in_valid   = 1'b0;
        wbus.in_sel     = 1'b0;
        wbus.in_data    = 8'h00;
        wbus.out0_ready = 1'b1;
        wbus.out1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with consumers ready; in_ready rises afterwards.
        doReset(2, 1'b1, 1'b1);
        tick("post_reset");
        chk("post_reset.cnt0", 32'(cnt0), 32'h0);

        // Route one beat to each lane.
        drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1); tick("route.a5");
        drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1); tick("route.3c");
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); tick("route.idle");
        tick("route.idle2");
        chk("route.cnt0_final", 32'(cnt0), 32'd1);
        chk("route.cnt1_final", 32'(cnt1), 32'd1);

        // Lane 0 stalled and full; lane 1 must still flow.
        drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1); tick("iso.load11");
        drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b1); tick("iso.blocked");
        drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b1); tick("iso.lane1");
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1); tick("iso.hold");
        tick("iso.hold2");
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); tick("iso.release");
        tick("iso.done");

        // Back-to-back stream on lane 1 from a clean start.
        doReset(1, 1'b1, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b1, 1'b1);
            tick("b2b.beat");
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick("b2b.tail");
        tick("b2b.end");
        chk("b2b.cnt1", 32'(cnt1), 32'd16);
        chk("b2b.cnt0", 32'(cnt0), 32'd0);

        // Reset with both lanes full and ready high: nothing may be counted.
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0); tick("mid.fill0");
        drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b0); tick("mid.fill1");
        chk("mid.both_full", 32'({bus.out1_valid, bus.out0_valid}), 32'h3);
        doReset(1, 1'b1, 1'b1);
        chk("mid.cnt0", 32'(cnt0), 32'd0);
        chk("mid.cnt1", 32'(cnt1), 32'd0);
        drive(1'b1, 1'b0, 8'h7E, 1'b1, 1'b1); tick("mid.7e");
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1); tick("mid.7e_out");
        tick("mid.7e_done");
        chk("mid.cnt0_after", 32'(cnt0), 32'd1);

        // Random traffic; the producer holds its beat while stalled.
        for (int c = 0; c < 400; c++) begin
            if (!lastStall) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sel   = 1'($urandom_range(0, 1));
                bus.in_data  = 8'($urandom);
            end
            bus.out0_ready = ($urandom_range(0, 2) != 0);
            bus.out1_ready = ($urandom_range(0, 2) != 0);
            tick("rand");
        end

        // Counter wrap on the 4-bit instance: 17 drains on lane 0.
        doReset(1, 1'b1, 1'b1);
        for (int j = 0; j < 19; j++) begin
            wbus.in_valid = (j < 17);
            wbus.in_sel   = 1'b0;
            wbus.in_data  = 8'(j);
            #1;
            chk("wrap.cnt0", 32'(wcnt0), 32'(((j > 0) ? (j - 1) : 0) % 16));
            @(posedge clk);
            @(negedge clk);
        end
        chk("wrap.cnt1", 32'(wcnt1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
